sseg_scan_ctrl: RTL
===================

SSEG_SCAN_CTRL -- requirements
Module: sseg_scan_ctrl

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed digits; legal range 2..8.
REQ-002 Parameter REFRESH_DIV, default 100000: clk cycles per digit slot; must be at least 2.
REQ-003 Parameter BLANK_CYC, default 2: anti-ghost cycles at the start of each slot; legal range 0..REFRESH_DIV-1.
REQ-004 Parameter BLINK_FRAMES, default 64: full scan frames per blink half-period; must be at least 1.
REQ-005 clk  in  1  sole clock; all logic on posedge; one clock; reset is synchronous and active-low.
REQ-006 rst_n  in  1  synchronous active-low reset.
REQ-007 value  in  4*NUM_DIGITS  hex nibbles; nibble i drives digit i; digit 0 is rightmost.
REQ-008 dp  in  NUM_DIGITS  decimal-point request per digit, active-high.
REQ-009 blink_mask  in  NUM_DIGITS  per-digit blink enable, active-high.
REQ-010 blank_lz  in  1  leading-zero blanking enable.
REQ-011 enable  in  1  display enable; 0 turns all anodes off while scanning continues.
REQ-012 an  out  NUM_DIGITS  anode drives, active-low, at most one bit low.
REQ-013 seg  out  7  segments a..g, active-low.
REQ-014 dp_n  out  1  decimal-point segment, active-low.
REQ-015 digit_idx  out  $clog2(NUM_DIGITS)  index of the current slot.
REQ-016 frame_done  out  1  one-cycle pulse on the last cycle of slot NUM_DIGITS-1.

Function
REQ-017 Slot counter: counts 0..REFRESH_DIV-1, then wraps.
REQ-018 digit_idx: increments at each slot-counter wrap, going NUM_DIGITS-1 -> 0; works for non-power-of-2 NUM_DIGITS.
REQ-019 Frame shadow: value, dp, blink_mask and blank_lz are captured into shadow registers on the cycle frame_done is high (and at reset); display uses only shadow copies, so no tearing within a frame.
REQ-020 Anode timing: an[digit_idx] is low only when all of the following hold:
- slot count >= BLANK_CYC
- enable is 1
- the digit is not blanked
- the digit is not blink-suppressed.
REQ-021 All other anode bits are high.
REQ-022 Leading-zero blanking: when shadow blank_lz=1, digit i>0 is blanked if shadow nibbles i..NUM_DIGITS-1 are all zero; digit 0 is never blanked.
REQ-023 Blink: a frame counter counts frame_done pulses modulo BLINK_FRAMES and toggles blink_phase at each wrap. While blink_phase=1, digits whose shadow blink_mask bit is 1 are suppressed.
REQ-024 seg: equals the hex_to_sseg encoding of the shadow nibble at digit_idx; dp_n equals ~shadow dp[digit_idx].
REQ-025 Registering: an, seg and dp_n are registered outputs, one clk after the internal slot state; digit_idx and frame_done are aligned with that same registered state.
REQ-026 An enable change takes effect on an within 1 cycle, without waiting for a frame boundary.

Reset
REQ-027 While rst_n=0 at a posedge, the block sets:
- slot counter, digit_idx, frame counter and blink_phase to 0
- an to all ones
- seg to 7'h7F and dp_n to 1
- frame_done to 0
- shadow registers to the current inputs.
REQ-028 The first slot after reset release is digit 0 with the full BLANK_CYC interval; a mid-frame reset abandons the frame with no frame_done.

Structure
REQ-029 Package sseg_pkg holds the active-low segment constants SEG_BLANK=7'h7F and the 16-entry hex glyph table.
REQ-030 One sub-module, hex_to_sseg: combinational 4-bit to 7-bit active-low decoder, instantiated once on the muxed shadow nibble.

Verification
REQ-031 All scenarios use NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYC=1, BLINK_FRAMES=2.
REQ-032 Scan: value=16'h1234, enable=1, masks 0.
- an sequence per slot: 1111,1110,1110,1110 then same pattern for 1101,1011,0111.
- seg shows 4,3,2,1 in turn.
- frame_done fires every 16 cycles.
REQ-033 Leading zeros: value=16'h0050, blank_lz=1 -> digits 3 and 2 keep an high and digits 1 and 0 light. value=16'h0000 -> only digit 0 lights, showing 0.
REQ-034 Blink: blink_mask=4'b0001 -> digit 0 is lit in frames 0-1, dark in frames 2-3, lit in frames 4-5; other digits are always lit.
REQ-035 Tear-free: change value from 16'h1111 to 16'h2222 mid-frame -> the rest of that frame shows 1, and the next frame shows 2 on all digits.
REQ-036 Reset and enable: assert rst_n=0 mid-frame -> next cycle an=1111, seg=7F, digit_idx=0. enable=0 -> an=1111 one cycle later while digit_idx keeps advancing.

Source files
------------

// File: rtl/sseg_pkg.sv
// +----------------------------------------------------------------------+
// | sseg_pkg                                                             |
// | Active-low seven-segment constants and hex glyph table.              |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package sseg_pkg;

  typedef logic [3:0] nibble_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Bit 0 is segment a, bit 6 is segment g; a 0 lights the segment.
  localparam logic [15:0][6:0] HEX_GLYPH = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

`default_nettype wire

// File: rtl/hex_to_sseg.sv
// +----------------------------------------------------------------------+
// | hex_to_sseg                                                          |
// | Combinational hex nibble to active-low seven-segment decoder.        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module hex_to_sseg
  import sseg_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX_GLYPH[hex_i];

endmodule

`default_nettype wire

// File: rtl/sseg_scan_ctrl.sv
// +----------------------------------------------------------------------+
// | sseg_scan_ctrl                                                       |
// | Multiplexed seven-segment scanner with frame shadowing, leading-zero |
// | blanking, blink and anti-ghost blanking. Rev 1.0                     |
// +----------------------------------------------------------------------+
`default_nettype none

module sseg_scan_ctrl
  import sseg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYC    = 2,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [4*NUM_DIGITS-1:0]       value,
  input  logic [NUM_DIGITS-1:0]         dp,
  input  logic [NUM_DIGITS-1:0]         blink_mask,
  input  logic                          blank_lz,
  input  logic                          enable,
  output logic [NUM_DIGITS-1:0]         an,
  output logic [6:0]                    seg,
  output logic                          dp_n,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          frame_done
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int DIG_W = $clog2(NUM_DIGITS);
  localparam int FR_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_C  = CNT_W'(BLANK_CYC);
  localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(NUM_DIGITS - 1);
  localparam logic [FR_W-1:0]  FR_LAST  = FR_W'(BLINK_FRAMES - 1);

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DIG_W-1:0]        dig_q, dig_d;
  logic [FR_W-1:0]         fcnt_q, fcnt_d;
  logic                    blink_q, blink_d;
  logic [4*NUM_DIGITS-1:0] val_sh_q, val_sh_d;
  logic [NUM_DIGITS-1:0]   dp_sh_q, dp_sh_d;
  logic [NUM_DIGITS-1:0]   mask_sh_q, mask_sh_d;
  logic                    lz_sh_q, lz_sh_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q;
  logic                    dp_n_q, dp_n_d;
  logic [DIG_W-1:0]        idx_q;
  logic                    fd_q, fd_d;

  nibble_t                 cur_nib;
  logic [NUM_DIGITS-1:0]   lz_vec;
  logic                    all_zero;
  logic                    lit;
  logic [6:0]              seg_w;

  hex_to_sseg u_dec (
    .hex_i (cur_nib),
    .seg_o (seg_w)
  );

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    dig_d = dig_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      dig_d = (dig_q == DIG_LAST) ? '0 : dig_q + DIG_W'(1);
    end
    fd_d = (cnt_q == CNT_LAST) && (dig_q == DIG_LAST);

    // Next-shadow is used for display so the first slot of a frame already
    // sees the freshly captured inputs.
    val_sh_d  = frame_done ? value      : val_sh_q;
    dp_sh_d   = frame_done ? dp         : dp_sh_q;
    mask_sh_d = frame_done ? blink_mask : mask_sh_q;
    lz_sh_d   = frame_done ? blank_lz   : lz_sh_q;

    fcnt_d  = fcnt_q;
    blink_d = blink_q;
    if (frame_done) begin
      if (fcnt_q == FR_LAST) begin
        fcnt_d  = '0;
        blink_d = ~blink_q;
      end else begin
        fcnt_d = fcnt_q + FR_W'(1);
      end
    end

    cur_nib = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (dig_q == DIG_W'(i)) cur_nib = val_sh_d[4*i +: 4];
    end

    all_zero = 1'b1;
    lz_vec   = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      all_zero  = all_zero & (val_sh_d[4*i +: 4] == 4'h0);
      lz_vec[i] = all_zero & lz_sh_d;
    end

    lit = (cnt_q >= BLANK_C) && enable && !lz_vec[dig_q]
          && !(blink_d && mask_sh_d[dig_q]);
    an_d = '1;
    if (lit) an_d[dig_q] = 1'b0;
    dp_n_d = ~dp_sh_d[dig_q];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      dig_q     <= '0;
      fcnt_q    <= '0;
      blink_q   <= 1'b0;
      val_sh_q  <= value;
      dp_sh_q   <= dp;
      mask_sh_q <= blink_mask;
      lz_sh_q   <= blank_lz;
      an_q      <= '1;
      seg_q     <= SEG_BLANK;
      dp_n_q    <= 1'b1;
      idx_q     <= '0;
      fd_q      <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      dig_q     <= dig_d;
      fcnt_q    <= fcnt_d;
      blink_q   <= blink_d;
      val_sh_q  <= val_sh_d;
      dp_sh_q   <= dp_sh_d;
      mask_sh_q <= mask_sh_d;
      lz_sh_q   <= lz_sh_d;
      an_q      <= an_d;
      seg_q     <= seg_w;
      dp_n_q    <= dp_n_d;
      idx_q     <= dig_q;
      fd_q      <= fd_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp_n       = dp_n_q;
  assign digit_idx  = idx_q;
  assign frame_done = fd_q;

endmodule

`default_nettype wire
